// File: rtl/tage_u_sched_if.sv
// rtl/tage_u_sched_if.sv - update request and table write-port bundle for the TAGE u scheduler
interface tage_u_sched_if #(
    parameter int TBL_W  = 4,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 18,
    parameter int U_W    = 3
);
    logic              upd_valid;
    logic              upd_ready;
    logic [TBL_W-1:0]  upd_table;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;

    logic              wr_en;
    logic              wr_clr;
    logic [TBL_W-1:0]  wr_table;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [U_W-1:0]    wr_clr_mask;

    modport master (
        output upd_valid, upd_table, upd_addr, upd_data,
        input  upd_ready,
        input  wr_en, wr_clr, wr_table, wr_addr, wr_data, wr_clr_mask
    );

    modport slave (
        input  upd_valid, upd_table, upd_addr, upd_data,
        output upd_ready,
        output wr_en, wr_clr, wr_table, wr_addr, wr_data, wr_clr_mask
    );
endinterface

// File: rtl/tage_u_sched.sv
// rtl/tage_u_sched.sv - TAGE tagged-table write scheduler with TICK-driven usefulness sweep
module tage_u_sched #(
    parameter int NUM_TABLES = 12,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 18,
    parameter int U_W        = 3,
    parameter int TICK_W     = 19,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    tage_u_sched_if.slave  bus,
    input  logic           tick_inc,
    input  logic           tick_dec,
    output logic           sweep_busy,
    output logic           sweep_done
);
    localparam int TBL_W = $clog2(NUM_TABLES);
    localparam int CLR_W = (U_W > 1) ? $clog2(U_W) : 1;
    localparam int SW_W  = $clog2(STARVE_MAX + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = {{(TICK_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
    logic [SW_W-1:0]   starve_q, starve_d;
    logic [CLR_W-1:0]  clr_idx_q, clr_idx_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_clr_q, wr_clr_d;
    logic [TBL_W-1:0]  wr_table_q, wr_table_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [U_W-1:0]    wr_mask_q, wr_mask_d;
    logic              done_q, done_d;
    logic              upd_ready;
    logic              accept;

    // Ready comes only from registered state so the requester never sees a valid->ready loop.
    assign upd_ready = !((state_q == SWEEP) && (starve_q == SW_W'(STARVE_MAX)));
    assign accept    = bus.upd_valid && upd_ready;

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        sweep_addr_d = sweep_addr_q;
        starve_d     = starve_q;
        clr_idx_d    = clr_idx_q;
        wr_en_d      = 1'b0;
        wr_clr_d     = 1'b0;
        wr_table_d   = '0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        wr_mask_d    = '0;
        done_d       = 1'b0;

        if (accept) begin
            wr_en_d    = 1'b1;
            wr_table_d = bus.upd_table;
            wr_addr_d  = bus.upd_addr;
            wr_data_d  = bus.upd_data;
            if (state_q == SWEEP) begin
                starve_d = starve_q + SW_W'(1);
            end
        end else if (state_q == SWEEP) begin
            wr_en_d   = 1'b1;
            wr_clr_d  = 1'b1;
            wr_addr_d = sweep_addr_q;
            wr_mask_d = U_W'(1) << clr_idx_q;
            starve_d  = '0;
            if (sweep_addr_q == ADDR_LAST) begin
                done_d       = 1'b1;
                state_d      = IDLE;
                sweep_addr_d = '0;
                clr_idx_d    = (clr_idx_q == '0) ? CLR_W'(U_W - 1) : clr_idx_q - CLR_W'(1);
            end else begin
                sweep_addr_d = sweep_addr_q + ADDR_W'(1);
            end
        end

        if (state_q == IDLE) begin
            starve_d = '0;
            if (tick_inc && !tick_dec) begin
                // Reaching the all-ones value is replaced by restarting from 0 and sweeping.
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = SWEEP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end else if (tick_dec && !tick_inc && (tick_q != '0)) begin
                tick_d = tick_q - TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            sweep_addr_q <= '0;
            starve_q     <= '0;
            clr_idx_q    <= CLR_W'(U_W - 1);
            wr_en_q      <= 1'b0;
            wr_clr_q     <= 1'b0;
            wr_table_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_mask_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            sweep_addr_q <= sweep_addr_d;
            starve_q     <= starve_d;
            clr_idx_q    <= clr_idx_d;
            wr_en_q      <= wr_en_d;
            wr_clr_q     <= wr_clr_d;
            wr_table_q   <= wr_table_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_mask_q    <= wr_mask_d;
            done_q       <= done_d;
        end
    end

    assign bus.upd_ready   = upd_ready;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_clr      = wr_clr_q;
    assign bus.wr_table    = wr_table_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_clr_mask = wr_mask_q;
    assign sweep_busy      = (state_q == SWEEP);
    assign sweep_done      = done_q;
endmodule

// File: doc/tage_u_sched.md
# tage_u_sched

Write-port scheduler and usefulness-aging controller for the TAGE tagged tables T1..T12. It owns the shared write path into the tagged-table BRAMs and arbitrates between predictor update writes and a background sweep that clears one usefulness bit in every entry. It also keeps the TICK counter that decides when a sweep starts. It sits between the update/allocation logic and the table memories.

## Interface
- NUM_TABLES, 12: number of tagged tables; TBL_W = clog2(NUM_TABLES).
- ADDR_W, 11: address width of the largest table; smaller tables ignore the upper wr_addr bits.
- DATA_W, 18: width of one table write word.
- U_W, 3: usefulness counter width.
- TICK_W, 19: TICK counter width.
- STARVE_MAX, 8: maximum consecutive update grants allowed while a sweep is pending.
- clk  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- upd_valid  in  1  update write request.
- upd_ready  out  1  update request accepted this cycle (combinational).
- upd_table  in  TBL_W  target table index.
- upd_addr  in  ADDR_W  target entry.
- upd_data  in  DATA_W  full entry write data.
- tick_inc  in  1  allocation failed; increment TICK.
- tick_dec  in  1  allocation succeeded; decrement TICK.
- wr_en  out  1  write strobe to the tables (registered).
- wr_clr  out  1  1 = broadcast usefulness-clear to all tables; 0 = normal update write to wr_table.
- wr_table  out  TBL_W  update target; 0 when wr_clr=1.
- wr_addr  out  ADDR_W  entry address.
- wr_data  out  DATA_W  update data; 0 when wr_clr=1.
- wr_clr_mask  out  U_W  one-hot mask of the u bit to clear; 0 when wr_clr=0.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse marking the final clear write.

## Operation
- Reset (reset=0, asynchronous) clears all registers.
  - Outputs become 0.
  - TICK=0, sweep address=0, starve_cnt=0, clear-bit index=U_W-1.
  - Reset mid-sweep aborts the sweep; no partial state survives.
- TICK counter, idle state only (sweep_busy=0):
  - tick_inc alone: +1.
  - tick_dec alone: -1, saturating at 0.
  - Both asserted: no change.
- Sweep start: an increment that would make TICK equal to 2^TICK_W-1 instead sets TICK=0 and sweep_busy=1 on the same edge.
- tick_inc and tick_dec are ignored while sweep_busy=1.
- States: IDLE (sweep_busy=0) and SWEEP (sweep_busy=1).
- upd_ready = !(sweep_busy && starve_cnt==STARVE_MAX).
- accept = upd_valid && upd_ready.
- Each cycle, exactly one of the following is registered onto the outputs:
  - accept: normal update write (wr_en=1, wr_clr=0, upd fields copied).
  - else if SWEEP: clear write at the sweep address (wr_en=1, wr_clr=1, wr_clr_mask=1<<clr_idx), then sweep address +1.
  - else: wr_en=0.
- starve_cnt behaviour:
  - In SWEEP, +1 on each accept.
  - Cleared to 0 on each issued clear write.
  - Held at 0 in IDLE.
  - It never exceeds STARVE_MAX.
- Sweep completion, on issuing the clear for address 2^ADDR_W-1, on that same edge:
  - sweep_done=1 for one cycle;
  - sweep_busy=0;
  - sweep address wraps to 0;
  - clr_idx decrements modulo U_W (U_W-1 wraps down to 0, then back to U_W-1).
- Because all tables are written in parallel, a sweep issues exactly 2^ADDR_W clear writes.

## Timing
- Accepted update: appears on wr_* exactly 1 cycle after acceptance.
- Updates have priority, so a sweep takes between 2^ADDR_W and 2^ADDR_W·(STARVE_MAX+1) cycles.
- Under saturated update traffic, a clear is guaranteed on at least every (STARVE_MAX+1)-th cycle.
- First clear write: 1 cycle after sweep_busy rises, if no update is accepted in that cycle.
- The final clear write, sweep_done=1 and sweep_busy=0 are all visible in the same cycle.
- A new sweep requires TICK to count up again from 0; back-to-back sweeps are impossible.
- upd_ready depends only on registered state, never on upd_valid.
- No write is ever dropped: at most one write per cycle and no internal queue.

## Test plan
Parameters for all scenarios: TICK_W=4, ADDR_W=3, U_W=2, STARVE_MAX=2.
- Reset, then upd_valid=1, table=5, addr=3, data=0x2A5 for one cycle -> next cycle wr_en=1, wr_clr=0, wr_table=5, wr_addr=3, wr_data=0x2A5; the following cycle wr_en=0.
- 14 tick_inc pulses -> TICK=14, idle; the 15th -> TICK=0, sweep_busy=1; then 8 consecutive clears on addr 0..7 with mask 2'b10; sweep_done pulses with addr 7.
- A second TICK saturation after the first sweep -> clears use mask 2'b01; a third sweep -> mask 2'b10 again.
- Continuous upd_valid during a sweep -> pattern is grant, grant, upd_ready=0 with a clear, repeating; the sweep completes in 24 cycles of write slots.
- tick_inc and tick_dec together 5 times -> TICK stays 0; tick_dec at 0 -> TICK stays 0; tick_inc during a sweep -> TICK stays 0.
- Reset pulse during a sweep after addr 4 -> outputs 0 immediately; after release, sweep_busy=0 and the next sweep starts at addr 0 with mask 2'b10.
